// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word reads to a synchronous instruction
// memory, presents one instruction per cycle to decode, honours backpressure
// and redirects, and latches a sticky error on an illegal fetch address.
module inst_fetch #(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              DP       = 256,
   parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_en,
   input  logic          redir_vld,
   input  logic [AW-1:0] redir_pc,
   output logic          mem_cs,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_dout,
   output logic          if_vld,
   input  logic          if_rdy,
   output logic [DW-1:0] if_inst,
   output logic [AW-1:0] if_pc,
   output logic          err,
   output logic [AW-1:0] err_pc,
   output logic [31:0]   fetch_cnt
);

   // Memory depth expressed at address width, compared against word indices.
   localparam logic [AW-1:0] LP_DP = AW'(DP);
   localparam logic [AW-1:0] LP_PC_STEP = AW'(4);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_req_vld;
   logic [AW-1:0] r_req_pc;
   logic [AW-1:0] r_pc;
   logic          r_err;
   logic [AW-1:0] r_err_pc;
   logic [31:0]   r_fetch_cnt;

   logic [AW-1:0] w_issue_pc;
   logic          w_redir_bad;
   logic          w_would_issue;
   logic          w_pc_bad;
   logic          w_err_det;
   logic          w_issue;
   logic          w_if_vld;
   logic          w_deliver;

   // A redirect overrides the sequential PC for this cycle's fetch.
   assign w_issue_pc = redir_vld ? redir_pc : r_pc;

   // Redirect targets must be word aligned and inside the memory.
   assign w_redir_bad = redir_vld &
                        ((redir_pc[1:0] != 2'b00) |
                         ({2'b00, redir_pc[AW-1:2]} >= LP_DP));

   // A fetch is wanted when running and the output slot is free, being
   // drained this cycle, or being discarded by a redirect.
   assign w_would_issue = (r_state == ST_RUN) & fetch_en &
                          (~r_req_vld | if_rdy | redir_vld);

   // Sequential fetch walking off the end of the memory.
   assign w_pc_bad = w_would_issue & ~redir_vld &
                     ({2'b00, r_pc[AW-1:2]} >= LP_DP);

   assign w_err_det = (r_state != ST_ERR) & (w_redir_bad | w_pc_bad);
   assign w_issue   = w_would_issue & ~w_err_det;

   // The in-flight instruction is hidden the cycle a redirect arrives.
   assign w_if_vld  = r_req_vld & ~redir_vld & (r_state != ST_ERR);
   assign w_deliver = w_if_vld & if_rdy;

   assign mem_cs    = w_issue;
   assign mem_addr  = {2'b00, w_issue_pc[AW-1:2]};
   assign if_vld    = w_if_vld;
   assign if_inst   = mem_dout;
   assign if_pc     = r_req_pc;
   assign err       = r_err;
   assign err_pc    = r_err_pc;
   assign fetch_cnt = r_fetch_cnt;

   // Next-state selection: ERR is absorbing, otherwise follow fetch_en.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_err_det) begin
               w_state_nxt = ST_ERR;
            end else if (fetch_en) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_err_det) begin
               w_state_nxt = ST_ERR;
            end else if (!fetch_en) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_ERR: begin
            w_state_nxt = ST_ERR;
         end
         default: begin
            w_state_nxt = ST_ERR;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fetch pipeline: outstanding request flag, its PC and the next PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_vld <= 1'b0;
         r_req_pc  <= {AW{1'b0}};
         r_pc      <= RESET_PC;
      end else if (r_state == ST_ERR) begin
         r_req_vld <= 1'b0;
      end else if (w_issue) begin
         r_req_vld <= 1'b1;
         r_req_pc  <= w_issue_pc;
         r_pc      <= w_issue_pc + LP_PC_STEP;
      end else if (w_err_det) begin
         r_req_vld <= 1'b0;
      end else if (redir_vld) begin
         r_req_vld <= 1'b0;
         r_pc      <= redir_pc;
      end else if (w_deliver) begin
         r_req_vld <= 1'b0;
      end
   end

   // Sticky error flag and the address that caused it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err    <= 1'b0;
         r_err_pc <= {AW{1'b0}};
      end else if (w_err_det) begin
         r_err    <= 1'b1;
         r_err_pc <= w_redir_bad ? redir_pc : r_pc;
      end
   end

   // Count instructions accepted by decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= 32'd0;
      end else if (w_deliver) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a behavioural memory, a queue of
// expected deliveries and directed cycle-by-cycle scenarios.
module tb_inst_fetch;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redir_vld;
   logic [31:0] redir_pc;
   logic        mem_cs;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic        if_vld;
   logic        if_rdy;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        err;
   logic [31:0] err_pc;
   logic [31:0] fetch_cnt;

   int          n_chk;
   int          n_err;
   logic [31:0] sb_q[$];
   logic [31:0] mon_pc;

   inst_fetch #(
      .AW(32), .DW(32), .DP(256), .RESET_PC(32'h0000_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redir_vld(redir_vld), .redir_pc(redir_pc),
      .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .if_vld(if_vld), .if_rdy(if_rdy), .if_inst(if_inst), .if_pc(if_pc),
      .err(err), .err_pc(err_pc), .fetch_cnt(fetch_cnt)
   );

   // Memory content is a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a ^ (a << 12)) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous memory: latches the address when strobed, holds otherwise.
   always @(posedge clk) begin
      if (mem_cs) mem_dout <= mem_word(mem_addr);
   end

   // Scoreboard: every accepted instruction must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && if_vld && if_rdy) begin
         if (sb_q.size() == 0) begin
            chk("sb_extra", if_pc, 32'hFFFF_FFFF);
         end else begin
            mon_pc = sb_q.pop_front();
            chk("dlv_pc", if_pc, mon_pc);
            chk("dlv_inst", if_inst, mem_word({2'b00, mon_pc[31:2]}));
         end
      end
   end

   // One cycle: drive inputs after the edge, optionally expect a delivery,
   // then return at the falling edge for sampling.
   task automatic cyc(input logic en, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic dlv, input logic [31:0] dpc);
      @(posedge clk);
      #1;
      fetch_en  = en;
      if_rdy    = rdy;
      redir_vld = rv;
      redir_pc  = rpc;
      if (dlv) sb_q.push_back(dpc);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      fetch_en  = 1'b0;
      if_rdy    = 1'b0;
      redir_vld = 1'b0;
      redir_pc  = 32'h0;
      @(negedge clk);
      chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
      chk("rst_if_vld", {31'd0, if_vld}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_err_pc", err_pc, 32'd0);
      chk("rst_cnt", fetch_cnt, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Directed scenarios.
   initial begin
      n_chk = 0; n_err = 0;
      rst_n = 1'b0; fetch_en = 1'b0; if_rdy = 1'b0;
      redir_vld = 1'b0; redir_pc = 32'h0; mem_dout = 32'h0;
      do_reset();

      // Sequential stream from RESET_PC.
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("idle_cs", {31'd0, mem_cs}, 32'd0);
      chk("idle_vld", {31'd0, if_vld}, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("seq_cs0", {31'd0, mem_cs}, 32'd1);
      chk("seq_addr0", mem_addr, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      chk("seq_addr1", mem_addr, 32'd1);
      chk("seq_vld1", {31'd0, if_vld}, 32'd1);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4);
      chk("seq_addr2", mem_addr, 32'd2);

      // Backpressure while word 2 is presented.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         chk("bp_cs", {31'd0, mem_cs}, 32'd0);
         chk("bp_vld", {31'd0, if_vld}, 32'd1);
         chk("bp_pc", if_pc, 32'h8);
         chk("bp_inst", if_inst, mem_word(32'd2));
      end
      chk("bp_cnt", fetch_cnt, 32'd2);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8);
      chk("rel_cs", {31'd0, mem_cs}, 32'd1);
      chk("rel_addr", mem_addr, 32'd3);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC);
      chk("cnt3", fetch_cnt, 32'd3);
      chk("seq_addr4", mem_addr, 32'd4);

      // Redirect discards the in-flight 0x10.
      cyc(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
      chk("rd_vld", {31'd0, if_vld}, 32'd0);
      chk("rd_cs", {31'd0, mem_cs}, 32'd1);
      chk("rd_addr", mem_addr, 32'h10);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
      chk("rd_pc0", if_pc, 32'h40);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h44);
      chk("rd_pc1", if_pc, 32'h44);

      // fetch_en drop: outstanding 0x48 still delivered, then nothing.
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h48);
      chk("off_cs", {31'd0, mem_cs}, 32'd0);
      chk("off_vld", {31'd0, if_vld}, 32'd1);
      chk("off_cnt", fetch_cnt, 32'd6);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("off_vld2", {31'd0, if_vld}, 32'd0);
      chk("off_cnt2", fetch_cnt, 32'd7);

      // Redirect in IDLE steers the first fetch.
      cyc(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
      chk("ird_cs", {31'd0, mem_cs}, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("ird_addr", mem_addr, 32'h20);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("ird_cs2", {31'd0, mem_cs}, 32'd1);
      chk("ird_addr2", mem_addr, 32'h20);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);

      // Reset mid-stream with 0x84 in flight.
      do_reset();
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("rs_addr", mem_addr, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("rs_cs", {31'd0, mem_cs}, 32'd1);
      chk("rs_addr2", mem_addr, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);

      // Misaligned redirect locks the block in ERR.
      cyc(1'b1, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
      chk("mis_cs", {31'd0, mem_cs}, 32'd0);
      chk("mis_vld", {31'd0, if_vld}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         chk("mis_err", {31'd0, err}, 32'd1);
         chk("mis_err_pc", err_pc, 32'h42);
         chk("mis_cs_hold", {31'd0, mem_cs}, 32'd0);
         chk("mis_vld_hold", {31'd0, if_vld}, 32'd0);
      end
      chk("mis_cnt", fetch_cnt, 32'd1);

      // End of memory: 0x3FC delivered, word 256 never strobed.
      do_reset();
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 32'h3F8, 1'b0, 32'h0);
      chk("end_addr0", mem_addr, 32'hFE);
      chk("end_cs0", {31'd0, mem_cs}, 32'd1);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3F8);
      chk("end_addr1", mem_addr, 32'hFF);
      chk("end_cs1", {31'd0, mem_cs}, 32'd1);
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3FC);
      chk("end_pc", if_pc, 32'h3FC);
      chk("end_cs2", {31'd0, mem_cs}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         chk("end_err", {31'd0, err}, 32'd1);
         chk("end_err_pc", err_pc, 32'h400);
         chk("end_cs_hold", {31'd0, mem_cs}, 32'd0);
         chk("end_vld", {31'd0, if_vld}, 32'd0);
      end
      chk("end_cnt", fetch_cnt, 32'd2);

      chk("sb_left", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter AW, 32: address width of PC and memory address.
REQ-002 Parameter DW, 32: instruction width.
REQ-003 Parameter DP, 256: instruction memory depth in words; legal PC range is word index 0..DP-1.
REQ-004 Parameter RESET_PC, 0: byte address of the first fetch after reset.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
REQ-006 Control ports:
- fetch_en  in  1: permits new fetches.
- redir_vld  in  1: redirect request, e.g. branch or jump.
- redir_pc  in  AW: redirect target byte address.
REQ-007 Memory ports:
- mem_cs  out  1: memory read strobe; the memory latches mem_addr on the clock edge where mem_cs=1.
- mem_addr  out  AW: word address, equal to issue_pc[AW-1:2] zero-extended.
- mem_dout  in  DW: memory data, valid the cycle after the strobe and held while mem_cs=0.
REQ-008 Decode-side ports:
- if_vld  out  1: instruction valid.
- if_rdy  in  1: decode accepts.
- if_inst  out  DW: instruction.
- if_pc  out  AW: byte PC of if_inst.
REQ-009 Status ports:
- err  out  1: sticky fetch error.
- err_pc  out  AW: offending PC.
- fetch_cnt  out  32: count of delivered instructions.

Function
REQ-010 The block SHALL have three states: IDLE, RUN and ERR.
- IDLE->RUN when fetch_en=1.
- RUN->IDLE when fetch_en=0.
- Any state except ERR goes to ERR on an error (REQ-017).
- ERR is left only by reset.
REQ-011 The internal signal issue SHALL equal (state==RUN) & fetch_en & (~req_vld_q | if_rdy | redir_vld) & no error this cycle.
REQ-012 The internal signal issue_pc SHALL equal redir_pc when redir_vld=1, and pc_q otherwise.
REQ-013 mem_cs SHALL equal issue, and mem_addr SHALL be derived from issue_pc combinationally.
REQ-014 On issue, the block SHALL set req_vld_q<=1, req_pc_q<=issue_pc and pc_q<=issue_pc+4, with pc_q wrapping modulo 2^AW.
REQ-015 Outputs to decode:
- if_vld = req_vld_q & ~redir_vld & (state!=ERR).
- if_inst = mem_dout.
- if_pc = req_pc_q.
REQ-016 Hold and redirect behaviour:
- Without issue, if_vld & if_rdy SHALL clear req_vld_q.
- While if_vld=1 and if_rdy=0, mem_cs SHALL stay 0 so mem_dout holds.
- A redirect without issue (IDLE, or fetch_en=0) SHALL clear req_vld_q and load pc_q<=redir_pc.
REQ-017 An error SHALL occur in either case:
- redir_vld=1 with redir_pc[1:0]!=0 or redir_pc[AW-1:2]>=DP;
- a would-be issue from pc_q with pc_q[AW-1:2]>=DP.
On error, err<=1 and err_pc<=the offending PC.
REQ-018 In ERR, mem_cs=0, if_vld=0 and req_vld_q<=0.
REQ-019 fetch_cnt SHALL increment by 1 on each cycle with if_vld & if_rdy, wrapping at 2^32.
REQ-020 Throughput SHALL be one instruction per cycle when if_rdy=1 and there is no redirect.
REQ-021 Latency from issue to if_vld SHALL be 1 cycle.
REQ-022 A redirect SHALL discard the in-flight instruction in the same cycle, and the target SHALL appear on if_vld the next cycle.
REQ-023 A redirect with if_rdy=1 in the same cycle SHALL NOT count as a delivery, since if_vld=0.

Reset
REQ-024 On rst_n=0, the block SHALL asynchronously set:
- state=IDLE, pc_q=RESET_PC, req_vld_q=0, req_pc_q=0;
- err=0, err_pc=0, fetch_cnt=0;
- hence mem_cs=0 and if_vld=0.
REQ-025 Reset mid-operation SHALL drop any in-flight instruction with no delivery, and the first fetch after reset and fetch_en=1 SHALL be RESET_PC.

Verification
REQ-026 Reset, then fetch_en=1 with if_rdy=1:
- mem_addr SHALL be 0,1,2,3 on consecutive cycles;
- if_pc SHALL be 0x0,0x4,0x8 one cycle later;
- fetch_cnt SHALL equal 3 after 3 deliveries.
REQ-027 Backpressure: with if_rdy=0 for 4 cycles while if_pc=0x8:
- mem_cs SHALL be 0, if_vld SHALL be 1, and if_inst SHALL stay the word-2 data;
- after if_rdy=1, the next if_pc SHALL be 0xC.
REQ-028 Redirect: redir_vld=1, redir_pc=0x40 while if_vld=1:
- if_vld SHALL be 0 that cycle, with mem_addr=0x10;
- the next cycle SHALL give if_pc=0x40, then 0x44.
REQ-029 Misaligned redirect: redir_pc=0x42 SHALL give:
- err=1 and err_pc=0x42 the next cycle;
- mem_cs=0 and if_vld=0 thereafter until rst_n=0.
REQ-030 Range end with DP=256: sequential fetch SHALL deliver 0x3FC, then raise err with err_pc=0x400 and produce no memory strobe for word 256.
REQ-031 Further cases:
- fetch_en=0 mid-stream SHALL deliver the outstanding instruction, then hold if_vld=0;
- a redirect while in IDLE SHALL make the first fetch after fetch_en=1 use redir_pc;
- rst_n pulsed mid-stream SHALL give if_vld=0, fetch_cnt=0 and a restart at RESET_PC.
